// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Sits downstream of the per-bit ALU result multiplexers. It captures each
// assembled result (plus carry-out, overflow and the op class) into a
// 2-entry FIFO that feeds register-file write-back. The architectural
// Z/N/C/V flags are updated only when an entry is committed (popped).
//
// Handshakes (both sides): a transfer happens on a rising Clock edge where
// valid and ready are both 1. A producer holds valid and its payload stable
// until the transfer; ready never depends on the other side's valid, and
// in_ready does not look at wb_ready (a full FIFO accepts nothing, even
// when it is popped in the same cycle).
//
// Ports:
//   Clock, Reset_n       rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  execute-stage handshake
//   Rezultati            assembled WIDTH-bit ALU result
//   CarryOut, Overflow   carry and signed overflow from the MSB slice
//   S                    ALU select; S[2]=1 marks an adder (arithmetic) op
//   dest                 destination register address
//   wb_valid / wb_ready  write-back handshake for the head entry
//   wb_data, wb_dest     head entry payload (0 while the FIFO is empty)
//   flag_Z/N/C/V         committed status flags
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Rezultati,
  input  logic             CarryOut,
  input  logic             Overflow,
  input  logic [2:0]       S,
  input  logic [AW-1:0]    dest,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [AW-1:0]    wb_dest,
  output logic             flag_Z,
  output logic             flag_N,
  output logic             flag_C,
  output logic             flag_V
);

  // Storage for the two entries, indexed by 1-bit pointers.
  logic [WIDTH-1:0] mem_data [2];
  logic [AW-1:0]    mem_dest [2];
  logic [1:0]       mem_c;
  logic [1:0]       mem_v;
  logic [1:0]       mem_arith;

  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;

  // Only the op class matters here; the low select bits distinguish logic
  // ops, which all behave the same for flag purposes.
  logic             unused_s;
  assign unused_s = ^S[1:0];

  assign in_ready = (count != 2'd2);
  assign wb_valid = (count != 2'd0);
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  // Head entry is read through the registered read pointer; nothing from
  // the input side reaches the output in the same cycle.
  always_comb begin
    wb_data = '0;
    wb_dest = '0;
    if (wb_valid) begin
      wb_data = mem_data[rd_ptr];
      wb_dest = mem_dest[rd_ptr];
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_dest[i] <= '0;
      end
      mem_c     <= '0;
      mem_v     <= '0;
      mem_arith <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr]  <= Rezultati;
        mem_dest[wr_ptr]  <= dest;
        mem_c[wr_ptr]     <= CarryOut;
        mem_v[wr_ptr]     <= Overflow;
        mem_arith[wr_ptr] <= S[2];
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Flags commit from the entry leaving the FIFO. Logic ops leave C/V
  // untouched, so a carry from an earlier add survives an AND/OR/XOR.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      flag_Z <= 1'b0;
      flag_N <= 1'b0;
      flag_C <= 1'b0;
      flag_V <= 1'b0;
    end else if (pop) begin
      flag_Z <= (mem_data[rd_ptr] == '0);
      flag_N <= mem_data[rd_ptr][WIDTH-1];
      if (mem_arith[rd_ptr]) begin
        flag_C <= mem_c[rd_ptr];
        flag_V <= mem_v[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int WIDTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic             Clock = 1'b0;
  logic             Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] Rezultati = '0;
  logic             CarryOut = 1'b0;
  logic             Overflow = 1'b0;
  logic [2:0]       S = 3'b000;
  logic [AW-1:0]    dest = '0;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [WIDTH-1:0] wb_data;
  logic [AW-1:0]    wb_dest;
  logic             flag_Z, flag_N, flag_C, flag_V;

  alu_result_stage #(.WIDTH(WIDTH), .AW(AW), .DEPTH(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Rezultati(Rezultati), .CarryOut(CarryOut), .Overflow(Overflow),
    .S(S), .dest(dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dest(wb_dest),
    .flag_Z(flag_Z), .flag_N(flag_N), .flag_C(flag_C), .flag_V(flag_V)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A bounded queue of results plus four flag bits; the rules are applied
  // directly to whole transfers.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    dst;
    logic             c;
    logic             v;
    logic             arith;
  } entry_t;

  entry_t     mq[$];
  logic [3:0] m_flags;  // {Z,N,C,V}
  int         pops_total = 0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mq.delete();
      m_flags = 4'b0000;
    end else begin
      bit do_push, do_pop;
      entry_t e;
      do_push = in_valid && (mq.size() < 2);
      do_pop  = wb_ready && (mq.size() > 0);
      if (do_pop) begin
        e = mq.pop_front();
        pops_total++;
        m_flags[3] = (e.data == 0);
        m_flags[2] = e.data[WIDTH-1];
        if (e.arith) m_flags[1:0] = {e.c, e.v};
      end
      if (do_push) begin
        e.data = Rezultati; e.dst = dest; e.c = CarryOut; e.v = Overflow; e.arith = S[2];
        mq.push_back(e);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge Clock) begin
    chk("in_ready", in_ready, (mq.size() < 2));
    chk("wb_valid", wb_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      chk("wb_data", wb_data, mq[0].data);
      chk("wb_dest", wb_dest, mq[0].dst);
    end
    chk("flags", {flag_Z, flag_N, flag_C, flag_V}, m_flags);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [2:0] s,
                       input logic c, input logic o, input logic [AW-1:0] ds);
    in_valid = v; Rezultati = d; S = s; CarryOut = c; Overflow = o; dest = ds;
  endtask

  task automatic idle();
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0, '0);
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int pops_before;
    // Reset state
    #13;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_flags", {flag_Z, flag_N, flag_C, flag_V}, 4'b0000);
    Reset_n = 1'b1;
    step();

    // 1: adder result 0 into empty FIFO, popped immediately
    wb_ready = 1'b1;
    drive(1'b1, 16'h0000, 3'b100, 1'b1, 1'b0, 4'd3);
    step();
    idle();
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_data", wb_data, 16'h0000);
    chk("t1_wb_dest", wb_dest, 4'd3);
    step();
    chk("t1_flags", {flag_Z, flag_N, flag_C, flag_V}, 4'b1010);
    chk("t1_empty", wb_valid, 0);

    // 2: fill with wb_ready=0, third push rejected, then drain in order
    wb_ready = 1'b0;
    drive(1'b1, 16'h1234, 3'b000, 1'b0, 1'b0, 4'd1); step();
    drive(1'b1, 16'h8000, 3'b010, 1'b0, 1'b0, 4'd2); step();
    chk("t2_full", in_ready, 0);
    drive(1'b1, 16'hFFFF, 3'b011, 1'b0, 1'b0, 4'd7); step(); step();
    chk("t2_still_full", in_ready, 0);
    chk("t2_head_stable", wb_data, 16'h1234);
    idle();
    wb_ready = 1'b1;
    step();
    chk("t2_second", wb_data, 16'h8000);
    chk("t2_second_dest", wb_dest, 4'd2);
    step();
    chk("t2_drained", wb_valid, 0);
    chk("t2_flags", {flag_Z, flag_N, flag_C, flag_V}, 4'b0110);

    // 3: count=1, simultaneous push and pop
    wb_ready = 1'b0;
    drive(1'b1, 16'h0001, 3'b001, 1'b0, 1'b0, 4'd4); step();
    drive(1'b1, 16'h00F0, 3'b010, 1'b0, 1'b0, 4'd5);
    wb_ready = 1'b1;
    step();
    idle();
    wb_ready = 1'b0;
    chk("t3_valid", wb_valid, 1);
    chk("t3_data", wb_data, 16'h00F0);
    chk("t3_Z", flag_Z, 0);
    wb_ready = 1'b1;
    step();

    // 4: adder sets C,V; XOR keeps them
    drive(1'b1, 16'h7000, 3'b101, 1'b1, 1'b1, 4'd6); step();
    idle(); step();
    chk("t4_add_flags", {flag_Z, flag_N, flag_C, flag_V}, 4'b0011);
    drive(1'b1, 16'h8001, 3'b011, 1'b0, 1'b0, 4'd8); step();
    idle(); step();
    chk("t4_xor_flags", {flag_Z, flag_N, flag_C, flag_V}, 4'b0111);

    // 5: asynchronous reset with two entries queued
    wb_ready = 1'b0;
    drive(1'b1, 16'hA5A5, 3'b100, 1'b1, 1'b0, 4'd9); step();
    drive(1'b1, 16'h0F0F, 3'b000, 1'b0, 1'b0, 4'd10); step();
    idle();
    chk("t5_full", in_ready, 0);
    #1 Reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", wb_valid, 0);
    chk("t5_rst_data", wb_data, 16'h0000);
    chk("t5_rst_flags", {flag_Z, flag_N, flag_C, flag_V}, 4'b0000);
    chk("t5_rst_ready", in_ready, 1);
    step();
    chk("t5_rst_held_ready", in_ready, 1);
    #1 Reset_n = 1'b1;
    step();
    chk("t5_after_ready", in_ready, 1);
    chk("t5_after_valid", wb_valid, 0);

    // 6: streaming 8 results
    wb_ready = 1'b1;
    pops_before = pops_total;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(16'h1111 * (i + 1)), 3'(i), 1'(i % 2), 1'b0, 4'(i));
      step();
      chk("t6_ready", in_ready, 1);
    end
    idle();
    step();
    chk("t6_pops", pops_total - pops_before, 8);
    chk("t6_last_flags_N", flag_N, 1);  // 0x8888 committed last
    chk("t6_empty", wb_valid, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the per-bit ALU result multiplexers. Captures the assembled 16-bit ALU result, carry-out and overflow each time the execute stage presents one.
- Buffers results in a 2-entry FIFO toward register-file write-back, using a valid/ready handshake.
- Maintains the architectural Z/N/C/V status flags, updated only when a result is committed to write-back.

Parameters:
- WIDTH, 16, datapath width of the result
- AW, 4, register-file destination address width
- DEPTH, 2, FIFO entries (fixed at 2; other values unsupported)

Ports:
- Clock  input  1  system clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute stage presents a result
- in_ready  output  1  stage can accept (FIFO not full)
- Rezultati  input  WIDTH  assembled mux outputs, bit i from slice i
- CarryOut  input  1  carry out of MSB adder slice
- Overflow  input  1  signed overflow from MSB slice
- S  input  3  ALU select used for this result: 000/001 AND, 010 OR, 011 XOR, 1xx adder
- dest  input  AW  destination register
- wb_valid  output  1  head entry valid
- wb_ready  input  1  write-back accepts head
- wb_data  output  WIDTH  head result
- wb_dest  output  AW  head destination
- flag_Z  output  1  committed zero flag
- flag_N  output  1  committed negative flag
- flag_C  output  1  committed carry flag
- flag_V  output  1  committed overflow flag

Behaviour:
- Reset (Reset_n low, asynchronous, any time including mid-transfer):
  - FIFO emptied; count=0; read and write pointers = 0.
  - wb_valid=0, wb_data=0, wb_dest=0, flags all 0, in_ready=1 (in_ready is driven from count, so it reads 1 during reset).
- Entry contents: result, dest, C, V, arith flag (arith = S[2]). Z and N are computed at commit from the stored result.
- Push occurs when in_valid & in_ready at a rising edge.
- Pop occurs when wb_valid & wb_ready at a rising edge.
- in_ready = (count != 2). It is combinational from registered count and does not depend on wb_ready: no pass-through when full.
- wb_valid = (count != 0). wb_data and wb_dest come from the head entry through a registered-pointer mux; the FIFO is not bypassed.
- Latency: a push into an empty FIFO at edge N gives wb_valid=1 in the cycle after edge N. Minimum one cycle, no combinational in->out path.
- Simultaneous push and pop:
  - count=1: count stays 1, new entry becomes head next cycle.
  - count=2: push blocked by in_ready=0; pop alone occurs.
  - count=0: pop impossible.
- Pointers are 1-bit and wrap 1->0.
- Inputs are ignored while in_valid=0 or in_ready=0. The producer must hold in_valid and data stable until accepted.
- Holding wb_ready=0 keeps wb_data and wb_dest stable.
- Flags update at the same edge as a pop, using the popped entry; they are visible the next cycle:
  - Z = (result == 0); N = result[WIDTH-1].
  - If arith=1: C and V are loaded from the entry.
  - If arith=0: C and V retain their prior values.
- With no pop, the flags hold their value.

Test Plan:
- Reset, then push Rezultati=16'h0000, S=100, CarryOut=1, Overflow=0, dest=3 with wb_ready=1 -> wb_valid next cycle with wb_data=0, wb_dest=3. After the pop edge: Z=1, N=0, C=1, V=0.
- wb_ready=0; push 16'h1234, then 16'h8000, then attempt 16'hFFFF -> in_ready=0 after the second push, third is not accepted. Then wb_ready=1 -> pops 1234 then 8000 in order, and N=1 after the second pop.
- count=1 with head 16'h0001; push 16'h00F0 and pop in the same cycle -> count stays 1, wb_data=16'h00F0 the next cycle, Z=0.
- Adder op sets C=1, V=1; then XOR op (S=011) result 16'h8001 -> after the pop, N=1, Z=0, C=1, V=1 retained.
- Reset_n pulsed low asynchronously with 2 entries queued and wb_ready=0 -> wb_valid, flags and wb_data drop to 0 immediately; in_ready=1 while reset is held and after release.
- Continuous streaming of 8 results with in_valid=1 and wb_ready=1 -> one accepted per cycle after the first, outputs in order, no drops or duplicates.
